// File: rtl/neuron_mac_if.sv
// neuron_mac port bundle: activation stream, weight memory read port,
// bias input and result strobe.
interface neuron_mac_if #(
  parameter int addressWidth = 10,
  parameter int dataWidth    = 16
) ();
  logic                    in_valid;
  logic                    in_ready;
  logic [dataWidth-1:0]    in_data;
  logic [dataWidth-1:0]    bias;
  logic                    w_rd_en;
  logic [addressWidth-1:0] w_rd_addr;
  logic [dataWidth-1:0]    w_rd_data;
  logic                    out_valid;
  logic [dataWidth-1:0]    out_data;

  modport slave (
    input  in_valid, in_data, bias, w_rd_data,
    output in_ready, w_rd_en, w_rd_addr, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, bias, w_rd_data,
    input  in_ready, w_rd_en, w_rd_addr, out_valid, out_data
  );
endinterface

// File: rtl/neuron_mac.sv
// Single-neuron multiply-accumulate sequencer: weight fetch, saturating
// fixed-point MAC, bias add and one-cycle result strobe.
module neuron_mac #(
  parameter int numWeight    = 3,
  parameter int addressWidth = 10,
  parameter int dataWidth    = 16,
  parameter int fracBits     = 8
) (
  input logic         clk,
  input logic         rst_n,
  neuron_mac_if.slave io
);
  localparam int DW = dataWidth;
  localparam int PW = 2 * dataWidth;
  localparam int AW = addressWidth;
  localparam logic [AW-1:0] LAST = AW'(numWeight - 1);

  typedef logic signed [DW-1:0] word_t;
  typedef enum logic [1:0] {ACCUM, DRAIN1, DRAIN2, BIAS} state_e;

  localparam word_t MAXV = {1'b0, {(DW-1){1'b1}}};
  localparam word_t MINV = {1'b1, {(DW-1){1'b0}}};

  function automatic word_t sat_add(input word_t a, input word_t b);
    logic [DW:0] s;
    s = {a[DW-1], a} + {b[DW-1], b};
    if (s[DW] != s[DW-1]) return s[DW] ? MINV : MAXV;
    return s[DW-1:0];
  endfunction

  // floor shift, then clamp if the high bits are not a pure sign run
  function automatic word_t sat_prod(input logic signed [PW-1:0] p);
    logic signed [PW-1:0] sh;
    sh = p >>> fracBits;
    if (&sh[PW-1:DW-1] || ~|sh[PW-1:DW-1]) return sh[DW-1:0];
    return sh[PW-1] ? MINV : MAXV;
  endfunction

  state_e state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  word_t act_q, act_d;
  word_t prod_q, prod_d;
  word_t acc_q, acc_d;
  word_t out_q, out_d;
  logic mul_v_q, mul_v_d;
  logic prod_v_q, prod_v_d;
  logic out_v_q, out_v_d;
  logic ready, accept;
  word_t w;
  logic signed [PW-1:0] mul;

  always_comb begin
    w        = io.w_rd_data;
    mul      = {{DW{act_q[DW-1]}}, act_q} * {{DW{w[DW-1]}}, w};
    ready    = rst_n && (state_q == ACCUM);
    accept   = io.in_valid && ready;
    state_d  = state_q;
    idx_d    = idx_q;
    act_d    = accept ? io.in_data : act_q;
    mul_v_d  = accept;
    prod_v_d = mul_v_q;
    prod_d   = mul_v_q ? sat_prod(mul) : prod_q;
    acc_d    = prod_v_q ? sat_add(acc_q, prod_q) : acc_q;
    out_d    = out_q;
    out_v_d  = 1'b0;
    unique case (state_q)
      ACCUM: begin
        if (accept) begin
          if (idx_q == LAST) begin
            idx_d   = '0;
            state_d = DRAIN1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      DRAIN1: state_d = DRAIN2;
      DRAIN2: state_d = BIAS;
      BIAS: begin
        out_d   = sat_add(acc_q, io.bias);
        out_v_d = 1'b1;
        acc_d   = '0;
        state_d = ACCUM;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ACCUM;
      idx_q    <= '0;
      act_q    <= '0;
      mul_v_q  <= 1'b0;
      prod_q   <= '0;
      prod_v_q <= 1'b0;
      acc_q    <= '0;
      out_q    <= '0;
      out_v_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      act_q    <= act_d;
      mul_v_q  <= mul_v_d;
      prod_q   <= prod_d;
      prod_v_q <= prod_v_d;
      acc_q    <= acc_d;
      out_q    <= out_d;
      out_v_q  <= out_v_d;
    end
  end

  assign io.in_ready  = ready;
  assign io.w_rd_en   = accept;
  assign io.w_rd_addr = idx_q;
  assign io.out_valid = out_v_q;
  assign io.out_data  = out_q;
endmodule

// File: tb/tb_neuron_mac.sv
// Randomised and directed bench for neuron_mac against an arithmetic
// model of one neuron evaluation.
module tb_neuron_mac;
  localparam int NW = 3;
  localparam int AW = 10;
  localparam int DW = 16;
  localparam int FB = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  neuron_mac_if #(.addressWidth(AW), .dataWidth(DW)) io ();

  neuron_mac #(
    .numWeight(NW), .addressWidth(AW), .dataWidth(DW), .fracBits(FB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .io(io)
  );

  logic [15:0] wmem [NW];
  logic [15:0] wt_v [NW];
  logic [15:0] act_v [NW];

  always @(posedge clk)
    if (io.w_rd_en) io.w_rd_data <= wmem[io.w_rd_addr];

  int vecs = 0;
  int errs = 0;
  int cyc = 0;
  int n = 0;
  longint macc = 0;
  bit pend = 0;
  int fire = 0;
  int vedge = -10;
  logic [15:0] exp_data = '0;
  bit kv = 0;
  int kedge = 0;
  bit started = 0;
  int rd_cnt = 0;
  int acc_cyc[$];
  logic [15:0] res_log[$];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    vecs++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  function automatic longint sat(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // ready drops for the three cycles following the final accept
  function automatic bit rdy_exp();
    return rst_n && !(kv && cyc <= kedge + 2);
  endfunction

  always @(posedge clk) begin
    bit r;
    longint p;
    r = rdy_exp();
    cyc++;
    if (!rst_n) begin
      started = 1;
      n = 0;
      macc = 0;
      pend = 0;
      kv = 0;
      vedge = -10;
      exp_data = '0;
    end else begin
      if (pend && cyc == fire) begin
        exp_data = 16'(sat(macc + longint'($signed(io.bias))));
        vedge = cyc;
        pend = 0;
        macc = 0;
      end
      if (io.w_rd_en) rd_cnt++;
      if (io.in_valid && r) begin
        p = (longint'($signed(io.in_data)) *
             longint'($signed(wmem[n]))) >>> FB;
        macc = sat(macc + sat(p));
        acc_cyc.push_back(cyc);
        n++;
        if (n == NW) begin
          n = 0;
          pend = 1;
          fire = cyc + 3;
          kv = 1;
          kedge = cyc;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("in_ready", 32'(io.in_ready), 32'(rdy_exp()));
      chk("w_rd_en", 32'(io.w_rd_en), 32'(io.in_valid && rdy_exp()));
      chk("w_rd_addr", 32'(io.w_rd_addr), 32'(n));
      chk("out_valid", 32'(io.out_valid), 32'(vedge == cyc));
      chk("out_data", 32'(io.out_data), 32'(exp_data));
      if (io.out_valid) res_log.push_back(io.out_data);
    end
  end

  task automatic send(input logic [15:0] a);
    bit got;
    got = 0;
    io.in_valid = 1'b1;
    io.in_data = a;
    for (int t = 0; t < 30 && !got; t++) begin
      @(negedge clk);
      got = io.in_ready;
      @(posedge clk);
      #2;
    end
    if (!got) chk("accept_timeout", 0, 1);
  endtask

  task automatic run_eval(input logic [15:0] b, input int gap,
                          input bit hold);
    for (int i = 0; i < NW; i++) wmem[i] = wt_v[i];
    if (hold && !io.in_ready) begin
      io.in_valid = 1'b1;
      io.in_data = 16'hDEAD;
    end
    for (int t = 0; t < 30 && !io.in_ready; t++) begin
      @(posedge clk);
      #2;
    end
    if (!io.in_ready) chk("ready_timeout", 0, 1);
    io.bias = b;
    for (int i = 0; i < NW; i++) begin
      send(act_v[i]);
      io.in_valid = 1'b0;
      repeat (gap) begin
        @(posedge clk);
        #2;
      end
    end
  endtask

  task automatic wait_results(input int cnt);
    for (int t = 0; t < 40 && res_log.size() < cnt; t++) begin
      @(posedge clk);
      #2;
    end
    if (res_log.size() < cnt) chk("result_timeout", 32'(res_log.size()), 32'(cnt));
  endtask

  task automatic set_basic();
    wt_v = '{16'h0100, 16'h0200, 16'hFF80};
    act_v = '{16'h0100, 16'h0100, 16'h0200};
  endtask

  initial begin
    int base, rd0, s;
    io.in_valid = 1'b0;
    io.in_data = '0;
    io.bias = '0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #2;

    set_basic();
    base = res_log.size();
    run_eval(16'h0080, 0, 0);
    rd0 = rd_cnt;
    run_eval(16'h0080, 2, 1);
    wait_results(base + 2);
    chk("basic_sum", 32'(res_log[base]), 32'h0280);
    chk("gapped_sum", 32'(res_log[base+1]), 32'h0280);
    chk("gapped_reads", 32'(rd_cnt - rd0), 32'd3);

    base = res_log.size();
    run_eval(16'h0080, 0, 0);
    s = acc_cyc.size();
    wt_v = '{16'h0100, 16'h0100, 16'h0100};
    act_v = '{16'h0100, 16'h0100, 16'h0100};
    run_eval(16'h0000, 0, 1);
    wait_results(base + 2);
    chk("b2b_first", 32'(res_log[base]), 32'h0280);
    chk("b2b_second", 32'(res_log[base+1]), 32'h0300);
    chk("b2b_accept_gap", 32'(acc_cyc[s] - acc_cyc[s-1]), 32'd4);

    base = res_log.size();
    wt_v = '{16'h7FFF, 16'h7FFF, 16'h7FFF};
    act_v = '{16'h7FFF, 16'h7FFF, 16'h7FFF};
    run_eval(16'h7FFF, 0, 0);
    wait_results(base + 1);
    chk("sat_pos", 32'(res_log[base]), 32'h7FFF);

    base = res_log.size();
    wt_v = '{16'h8000, 16'h8000, 16'h8000};
    run_eval(16'h0000, 0, 0);
    wait_results(base + 1);
    chk("sat_neg", 32'(res_log[base]), 32'h8000);

    base = res_log.size();
    wt_v = '{16'h0100, 16'h0100, 16'h0100};
    act_v = '{16'hFFFF, 16'h0000, 16'h0000};
    run_eval(16'h0000, 0, 0);
    wait_results(base + 1);
    chk("truncate", 32'(res_log[base]), 32'hFFFF);

    base = res_log.size();
    set_basic();
    for (int i = 0; i < NW; i++) wmem[i] = wt_v[i];
    io.bias = 16'h0080;
    send(act_v[0]);
    send(act_v[1]);
    io.in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #2;
    chk("rst_no_valid", 32'(res_log.size()), 32'(base));
    chk("rst_out_data", 32'(io.out_data), 32'h0000);
    run_eval(16'h0080, 0, 0);
    wait_results(base + 1);
    chk("rst_resume", 32'(res_log[base]), 32'h0280);

    for (int e = 0; e < 25; e++) begin
      for (int i = 0; i < NW; i++) begin
        if ($urandom_range(1) == 1) begin
          wt_v[i] = 16'($urandom_range(0, 16'h03FF));
          act_v[i] = 16'($urandom_range(0, 16'h03FF));
          if ($urandom_range(1) == 1) wt_v[i] = -wt_v[i];
          if ($urandom_range(1) == 1) act_v[i] = -act_v[i];
        end else begin
          wt_v[i] = 16'($urandom);
          act_v[i] = 16'($urandom);
        end
      end
      run_eval(16'($urandom), int'($urandom_range(0, 2)),
               1'($urandom_range(1)));
    end
    base = res_log.size();
    repeat (10) @(posedge clk);
    #2;

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
